// File: rtl/can_tx_queue.sv
// Transmit message queue in front of tx_container: buffers 64-bit payloads, issues one-cycle
// send requests, retires entries on frame completion and retries/drops unacknowledged requests.
module can_tx_queue #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned START_TIMEOUT = 1000,
  parameter int unsigned MAX_RETRY     = 3
) (
  input  logic                     clk,
  input  logic                     RESET,
  input  logic                     wr_en,
  input  logic [63:0]              wr_data,
  input  logic                     txing,
  output logic [63:0]              tx_data,
  output logic                     send_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     tx_done,
  output logic                     drop_err,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned ToW  = $clog2(START_TIMEOUT) + 1;
  localparam int unsigned RtyW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [ToW-1:0]  ToLast  = ToW'(START_TIMEOUT - 1);
  localparam logic [ToW-1:0]  ToMax   = '1;
  localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitStart,
    StWaitDone,
    StPop,
    StDrop
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [63:0]       tx_data_q, tx_data_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [RtyW-1:0]   rty_q, rty_d;
  logic              overflow_q, overflow_d;
  logic              push, pop;

  assign full      = (count_q == CntFull);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign tx_data   = tx_data_q;
  assign overflow  = overflow_q;
  assign send_data = (state_q == StReq);
  assign tx_done   = (state_q == StPop);
  assign drop_err  = (state_q == StDrop);

  // full is taken from the pre-edge count, so a write while full is rejected even on a pop cycle
  assign push = wr_en && !full;

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    to_d      = to_q;
    rty_d     = rty_q;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty && !txing) begin
          tx_data_d = mem_q[rd_ptr_q];
          rty_d     = '0;
          state_d   = StReq;
        end
      end
      StReq: begin
        to_d    = '0;
        state_d = StWaitStart;
      end
      StWaitStart: begin
        if (txing) begin
          state_d = StWaitDone;
        end else if (to_q == ToLast) begin
          if (rty_q < RtyMax) begin
            rty_d   = rty_q + RtyW'(1);
            state_d = StReq;
          end else begin
            state_d = StDrop;
          end
        end else if (to_q != ToMax) begin
          to_d = to_q + ToW'(1);
        end
      end
      StWaitDone: begin
        if (!txing) begin
          state_d = StPop;
        end
      end
      StPop: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      StDrop: begin
        pop     = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_en & full);
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      to_q       <= '0;
      rty_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      to_q       <= to_d;
      rty_q      <= rty_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: tb/tb_can_tx_queue.sv
// Scoreboard bench for can_tx_queue: queued payloads are expected back in write order on each
// send request, with retry/drop, wrap-around and asynchronous reset scenarios.
module tb_can_tx_queue;

  localparam int unsigned DEPTH         = 4;
  localparam int unsigned START_TIMEOUT = 10;
  localparam int unsigned MAX_RETRY     = 3;
  localparam int unsigned CntW          = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            RESET = 1'b0;
  logic            wr_en = 1'b0;
  logic [63:0]     wr_data = '0;
  logic            txing = 1'b0;
  logic [63:0]     tx_data;
  logic            send_data;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic            tx_done;
  logic            drop_err;
  logic            overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] sb_q[$];
  bit          exp_ovf = 1'b0;

  can_tx_queue #(
    .DEPTH        (DEPTH),
    .START_TIMEOUT(START_TIMEOUT),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .txing    (txing),
    .tx_data  (tx_data),
    .send_data(send_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .tx_done  (tx_done),
    .drop_err (drop_err),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [63:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    if (sb_q.size() < DEPTH) sb_q.push_back(d);
    else exp_ovf = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // Waits for a request, plays tx_container for len cycles, checks retirement.
  task automatic serve_frame(input int len, input int exp_gap, input bit wr_pop,
                             input logic [63:0] pop_data);
    int          n;
    int          extra;
    bit          stable_ok;
    logic [63:0] exp;
    n = 0;
    while (send_data !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (send_data !== 1'b1) begin
      miscompares++;
      $display("FAIL send_wait: send_data=%b after %0d cycles, required 1", send_data, n);
      return;
    end
    if (exp_gap >= 0) begin
      vectors++;
      if (n != exp_gap) begin
        miscompares++;
        $display("FAIL send_latency: got %0d cycles, required %0d", n, exp_gap);
      end
    end
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_send: tx_data=%h, required no request", tx_data);
      return;
    end
    exp = sb_q[0];
    vectors++;
    if (tx_data !== exp) begin
      miscompares++;
      $display("FAIL tx_data: got %h, required %h", tx_data, exp);
    end
    txing     = 1'b1;
    stable_ok = 1'b1;
    extra     = 0;
    repeat (len) begin
      step();
      if (tx_data !== exp) stable_ok = 1'b0;
      if (send_data !== 1'b0) extra++;
    end
    txing = 1'b0;
    vectors++;
    if (!stable_ok) begin
      miscompares++;
      $display("FAIL tx_data_stable: now %h, required %h throughout", tx_data, exp);
    end
    vectors++;
    if (extra != 0) begin
      miscompares++;
      $display("FAIL extra_send: %0d pulses during frame, required 0", extra);
    end
    step();
    vectors++;
    if (tx_done !== 1'b1) begin
      miscompares++;
      $display("FAIL tx_done: got %b, required 1", tx_done);
    end
    void'(sb_q.pop_front());
    if (wr_pop) begin
      wr_en   = 1'b1;
      wr_data = pop_data;
      if (sb_q.size() < DEPTH) sb_q.push_back(pop_data);
    end
    step();
    wr_en = 1'b0;
    vectors++;
    if (count !== CntW'(sb_q.size())) begin
      miscompares++;
      $display("FAIL count_after_pop: got %0d, required %0d", count, sb_q.size());
    end
    vectors++;
    if (tx_done !== 1'b0) begin
      miscompares++;
      $display("FAIL tx_done_width: got %b, required 0", tx_done);
    end
  endtask

  task automatic test_reset();
    int sends;
    RESET = 1'b0;
    repeat (3) step();
    vectors++;
    if ({empty, full, send_data, tx_done, drop_err, overflow} !== 6'b100000 ||
        count !== '0 || tx_data !== '0) begin
      miscompares++;
      $display("FAIL reset_state: e/f/s/d/x/o=%b count=%0d tx_data=%h, required 100000 0 0",
               {empty, full, send_data, tx_done, drop_err, overflow}, count, tx_data);
    end
    RESET = 1'b1;
    sends = 0;
    repeat (100) begin
      step();
      if (send_data !== 1'b0) sends++;
    end
    vectors++;
    if (sends != 0) begin
      miscompares++;
      $display("FAIL idle_no_send: %0d pulses, required 0", sends);
    end
  endtask

  task automatic test_single_frame();
    write(64'h0123456789ABCDEF);
    vectors++;
    if (count !== CntW'(1) || empty !== 1'b0) begin
      miscompares++;
      $display("FAIL write_count: count=%0d empty=%b, required 1 0", count, empty);
    end
    serve_frame(50, 1, 1'b0, '0);
    vectors++;
    if (count !== '0 || empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_empty: count=%0d empty=%b, required 0 1", count, empty);
    end
  endtask

  task automatic test_fill_order();
    logic [63:0] pl [5];
    pl = '{64'hA0A0_0000_0000_0001, 64'hB1B1_0000_0000_0002, 64'hC2C2_0000_0000_0003,
           64'hD3D3_0000_0000_0004, 64'hE4E4_0000_0000_0005};
    txing = 1'b1;  // foreign frame in progress holds the queue in idle
    for (int i = 0; i < 5; i++) begin
      write(pl[i]);
      if (i >= 3) begin
        vectors++;
        if (full !== 1'b1 || count !== CntW'(sb_q.size())) begin
          miscompares++;
          $display("FAIL fill_full[%0d]: full=%b count=%0d, required 1 %0d", i, full, count,
                   sb_q.size());
        end
      end
      vectors++;
      if (overflow !== exp_ovf) begin
        miscompares++;
        $display("FAIL overflow[%0d]: got %b, required %b", i, overflow, exp_ovf);
      end
    end
    vectors++;
    if (send_data !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_hold: send_data=%b, required 0", send_data);
    end
    txing = 1'b0;
    for (int i = 0; i < 4; i++) serve_frame(6 + i, 1, 1'b0, '0);
    vectors++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_drained: empty=%b full=%b, required 1 0", empty, full);
    end
  endtask

  task automatic test_wrap_simul();
    txing = 1'b1;
    write(64'h1111_2222_3333_0001);
    write(64'h1111_2222_3333_0002);
    vectors++;
    if (count !== CntW'(2)) begin
      miscompares++;
      $display("FAIL wrap_setup: count=%0d, required 2", count);
    end
    txing = 1'b0;
    serve_frame(4, 1, 1'b1, 64'h1111_2222_3333_0003);
    serve_frame(4, 1, 1'b1, 64'h1111_2222_3333_0004);
    serve_frame(4, 1, 1'b1, 64'h1111_2222_3333_0005);
    serve_frame(4, 1, 1'b0, '0);
    serve_frame(4, 1, 1'b0, '0);
  endtask

  task automatic test_retry_drop();
    int sends[$];
    int drop_t;
    bit data_ok;
    txing = 1'b1;
    write(64'hDEAD_BEEF_0000_00AA);
    write(64'hCAFE_F00D_0000_00BB);
    txing   = 1'b0;
    drop_t  = -1;
    data_ok = 1'b1;
    for (int t = 1; t <= 120 && drop_t < 0; t++) begin
      step();
      if (send_data === 1'b1) begin
        sends.push_back(t);
        if (tx_data !== sb_q[0]) data_ok = 1'b0;
      end
      if (drop_err === 1'b1) drop_t = t;
    end
    vectors++;
    if (sends.size() != MAX_RETRY + 1) begin
      miscompares++;
      $display("FAIL retry_count: %0d requests, required %0d", sends.size(), MAX_RETRY + 1);
    end
    for (int i = 1; i < sends.size(); i++) begin
      vectors++;
      if (sends[i] - sends[i-1] != START_TIMEOUT + 1) begin
        miscompares++;
        $display("FAIL retry_spacing[%0d]: %0d cycles, required %0d", i, sends[i] - sends[i-1],
                 START_TIMEOUT + 1);
      end
    end
    vectors++;
    if (!data_ok) begin
      miscompares++;
      $display("FAIL retry_data: tx_data=%h, required %h", tx_data, sb_q[0]);
    end
    vectors++;
    if (drop_t < 0 || sends.size() == 0 ||
        drop_t - sends[0] != (MAX_RETRY + 1) * (START_TIMEOUT + 1)) begin
      miscompares++;
      $display("FAIL drop_time: drop at %0d, required %0d cycles after first request", drop_t,
               (MAX_RETRY + 1) * (START_TIMEOUT + 1));
    end
    if (drop_t >= 0) void'(sb_q.pop_front());
    step();
    vectors++;
    if (count !== CntW'(sb_q.size()) || drop_err !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_count: count=%0d drop_err=%b, required %0d 0", count, drop_err,
               sb_q.size());
    end
    serve_frame(5, 1, 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    int n;
    int events;
    txing = 1'b1;
    write(64'h0000_0000_0000_0F01);
    write(64'h0000_0000_0000_0F02);
    write(64'h0000_0000_0000_0F03);
    txing = 1'b0;
    n = 0;
    while (send_data !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (send_data !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_setup_send: send_data=%b, required 1", send_data);
    end
    txing = 1'b1;
    repeat (4) step();
    #2 RESET = 1'b0;
    #1;
    sb_q.delete();
    exp_ovf = 1'b0;
    vectors++;
    if (count !== '0 || send_data !== 1'b0 || empty !== 1'b1 || overflow !== exp_ovf) begin
      miscompares++;
      $display("FAIL async_reset: count=%0d send=%b empty=%b ovf=%b, required 0 0 1 0", count,
               send_data, empty, overflow);
    end
    step();
    txing = 1'b0;
    RESET = 1'b1;
    events = 0;
    repeat (40) begin
      step();
      if (tx_done !== 1'b0 || send_data !== 1'b0 || count !== '0) events++;
    end
    vectors++;
    if (events != 0) begin
      miscompares++;
      $display("FAIL post_reset_quiet: %0d active cycles, required 0", events);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_fill_order();
    test_wrap_simul();
    test_retry_drop();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
